ioctl_sdram_loader: RTL and testbench
=====================================

# ioctl_sdram_loader

Buffers the HPS ROM/BIOS download stream (`ioctl_*` from `hps_io`) and turns it into word writes on the SDRAM download port (port 2). It replaces the ad-hoc `ioctl_wait` logic in the top level with a small FIFO, byte swap, base-address mapping, flow control and a completion pulse. The Saturn core is held in reset until completion.

## Interface
- `ADDR_W`, default 24: SDRAM word-address width.
- `FIFO_DEPTH`, default 4: buffered words; power of two, ≥ 4.
- `BASE_ADDR`, default 24'h000000: word offset added to every download address.
- `clk`  in  1  system clock (clk_sys); all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ioctl_download`  in  1  download active.
- `ioctl_index`  in  8  download slot; 8'hFF (code slot) is ignored.
- `ioctl_wr`  in  1  one-cycle write strobe.
- `ioctl_addr`  in  25  byte address; bit 0 is ignored.
- `ioctl_data`  in  16  data as sent by HPS (little-endian byte order).
- `ioctl_wait`  out  1  registered back-pressure to `hps_io`.
- `sdr_addr`  out  ADDR_W  word address = BASE_ADDR + ioctl_addr[ADDR_W:1], modulo 2^ADDR_W.
- `sdr_din`  out  16  byte-swapped data {d[7:0], d[15:8]}.
- `sdr_wr`  out  1  write request, level; drives both wrl/wrh.
- `sdr_busy`  in  1  SDRAM port busy.
- `active`  out  1  high from first accepted write until done.
- `done`  out  1  one-cycle pulse when a download has fully landed in SDRAM.
- `overflow`  out  1  sticky; a write arrived while the FIFO was full.
- `checksum`  out  16  additive sum of written (swapped) words; see Configuration.

## Operation
- Accept condition: `ioctl_download & ioctl_wr & (ioctl_index != 8'hFF)`.
- Accepted beat: push {mapped address, swapped data} into the FIFO.
- If the FIFO is full, the beat is dropped, `overflow` is set, and the FIFO is unchanged.
- Writes are accepted even while `ioctl_wait` is high, provided the FIFO is not full.
- `ioctl_wait` is registered. Next value = (occupancy after this cycle's push/pop) ≥ FIFO_DEPTH-1. This leaves one slot of slack for the strobe that races the wait assertion.
- Write FSM:
  - IDLE: FIFO non-empty → REQ.
  - REQ: `sdr_wr`=1 with head address/data stable; `sdr_busy`=1 observed → ACK.
  - ACK: `sdr_wr` held; `sdr_busy` falling (1→0) → pop head. Go to REQ if more entries remain (pop counted), else IDLE.
- FIFO push and pop in the same cycle: occupancy unchanged; both take effect.
- Address wrap: the sum is truncated to ADDR_W; no error is flagged.
- Completion:
  - `active` rises on the first accepted beat.
  - `done` pulses once when `ioctl_download`=0, the FIFO is empty and the FSM is in IDLE while `active`=1. `active` clears on the same cycle.
  - If `ioctl_download` falls with data still buffered, the FIFO drains first, then `done` pulses.
- `overflow` and `checksum` clear on the first accepted beat of a new download (when `active`=0), not on `done`.

## Timing
- Reset values: `ioctl_wait`=0, `sdr_wr`=0, `sdr_addr`=0, `sdr_din`=0, `active`=0, `done`=0, `overflow`=0, `checksum`=0, FSM=IDLE, FIFO empty.
- Reset mid-transfer: the FIFO is discarded and `sdr_wr` is low on the cycle after `rst` is sampled. No partial pop.
- Latency: accepted beat at cycle N → `sdr_wr` high at N+2 (push at N, IDLE→REQ at N+1, REQ output at N+2) when the FIFO was empty.
- Pop happens the cycle after the busy falling edge is sampled. The next REQ presents the new head one cycle later.
- `ioctl_wait` is asserted one cycle after the occupancy threshold is reached. It deasserts one cycle after a pop brings occupancy below the threshold.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - `checksum` accumulates each word at its pop, 16-bit wrapping.
  - Final value is valid from the `done` cycle onward.
- `LOADER_CHECKSUM_EN` not defined: `checksum` is tied to 16'h0000 and no adder is built.

## Structure
- Shared package `saturn_loader_pkg`:
  - `loader_state_t` enum (IDLE, REQ, ACK).
  - `loader_entry_t` struct {addr, data}.
  - `LOADER_CODE_INDEX` = 8'hFF.
- One sub-module: `loader_fifo`, a synchronous FIFO of `loader_entry_t`.
  - Ports: push, pop, full, empty, count.
  - Same-cycle push+pop is legal when full or empty.
- FSM, wait logic, completion and checksum live in the top module.

## Test plan
- Single beat: index 0, addr 25'h000010, data 16'h3412, BASE 0, `sdr_busy` pulses 3 cycles → `sdr_addr`=24'h000008, `sdr_din`=16'h1234, one pop, then `done` pulse after `ioctl_download` falls.
- Back-pressure: hold `sdr_busy`=1 for 20 cycles, stream 8 beats with strobes spaced 2 cycles apart while obeying `ioctl_wait` → `ioctl_wait` rises once occupancy reaches 3, no `overflow`, all 8 words written in order.
- Overflow: ignore `ioctl_wait`, 5 beats with `sdr_busy` stuck high → 5th beat dropped, `overflow`=1, first 4 written after busy releases.
- Code slot ignored: index 8'hFF beats → no `sdr_wr`, `active` stays 0, no `done`.
- Reset mid-stream: `rst` asserted during ACK with 3 entries buffered → next cycle `sdr_wr`=0, FIFO empty, all outputs at reset values.
- Checksum (macro on): words 16'h0001, 16'hFFFF, 16'h0010 → `checksum`=16'h0010 at `done`; macro off → 16'h0000.

Source files
------------

// File: rtl/saturn_loader_pkg.sv
// Shared types for the HPS download loader.
// Contents: FSM state enum, FIFO entry payload struct, code-slot index,
// byte-swap helper used to convert the little-endian HPS stream to SDRAM order.
package saturn_loader_pkg;

   localparam int unsigned LOADER_ADDR_W = 24;
   localparam int unsigned LOADER_DATA_W = 16;

   // Download slot carrying the HPS core code; never written to SDRAM.
   localparam logic [7:0] LOADER_CODE_INDEX = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2
   } loader_state_t;

   typedef struct packed {
      logic [LOADER_ADDR_W-1:0] addr;
      logic [LOADER_DATA_W-1:0] data;
   } loader_entry_t;

   function automatic logic [LOADER_DATA_W-1:0] swap_bytes(input logic [LOADER_DATA_W-1:0] d);
      return {d[7:0], d[15:8]};
   endfunction

endpackage

// File: rtl/loader_fifo.sv
// Synchronous FIFO of loader_entry_t words.
// Ports: clk, rst (sync, active-high), push/din, pop/dout (head, valid when
// !empty), full, empty, count (occupancy 0..DEPTH).
// DEPTH must be a power of two so the pointers wrap naturally.
// Push and pop in the same cycle both take effect, also when full or empty
// (a pop on empty is ignored; a push on full is taken only alongside a pop).
module loader_fifo
   import saturn_loader_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  loader_entry_t       din,
   input  logic                pop,
   output loader_entry_t       dout,
   output logic                full,
   output logic                empty,
   output logic [CNT_W-1:0]    count
);

   loader_entry_t    mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_en_c;
   logic             pop_en_c;

   assign pop_en_c  = pop & (count_q != '0);
   assign push_en_c = push & ((count_q != CNT_W'(DEPTH)) | pop_en_c);

   // Pointer and occupancy update.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(push_en_c) - CNT_W'(pop_en_c);
      if (push_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_en_c) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/ioctl_sdram_loader.sv
// HPS ioctl download stream -> SDRAM download-port word writes.
// Buffers accepted beats in a small FIFO (mapped word address + byte-swapped
// data), raises ioctl_wait one slot before full, writes each word with a
// req/busy handshake and pulses done once a download has fully landed.
// Ports:
//   clk, rst                     system clock, sync active-high reset
//   ioctl_download/index/wr/addr/data, ioctl_wait   hps_io side
//   sdr_addr, sdr_din, sdr_wr, sdr_busy             SDRAM download port
//   active, done, overflow, checksum                status
// Build option: LOADER_CHECKSUM_EN adds a 16-bit wrapping sum of written words;
// without it checksum is tied to zero.
module ioctl_sdram_loader
   import saturn_loader_pkg::*;
#(
   parameter int unsigned              ADDR_W     = 24,
   parameter int unsigned              FIFO_DEPTH = 4,
   parameter logic [LOADER_ADDR_W-1:0] BASE_ADDR  = 24'h000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [15:0]       ioctl_data,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] sdr_addr,
   output logic [15:0]       sdr_din,
   output logic              sdr_wr,
   input  logic              sdr_busy,
   output logic              active,
   output logic              done,
   output logic              overflow,
   output logic [15:0]       checksum
);

   localparam int unsigned      CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] WAIT_LEVEL = CNT_W'(FIFO_DEPTH - 1);

   loader_state_t     state_q, state_d;
   logic              busy_q;
   logic              wait_q, wait_d;
   logic              sdr_wr_q, sdr_wr_d;
   logic [ADDR_W-1:0] sdr_addr_q, sdr_addr_d;
   logic [15:0]       sdr_din_q, sdr_din_d;
   logic              active_q, active_d;
   logic              done_q, done_d;
   logic              overflow_q, overflow_d;

   logic              accept_c;
   logic              push_c;
   logic              pop_c;
   logic              busy_fall_c;
   logic [ADDR_W-1:0] map_addr_c;
   logic [CNT_W-1:0]  count_next_c;
   loader_entry_t     push_entry_c;
   loader_entry_t     head_c;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              unused_bits_c;

   assign accept_c    = ioctl_download & ioctl_wr & (ioctl_index != LOADER_CODE_INDEX);
   assign push_c      = accept_c & ~fifo_full;
   assign busy_fall_c = busy_q & ~sdr_busy;

   // Byte address -> word address, offset and wrapped to ADDR_W.
   assign map_addr_c        = ioctl_addr[ADDR_W:1] + BASE_ADDR[ADDR_W-1:0];
   assign push_entry_c.addr = LOADER_ADDR_W'(map_addr_c);
   assign push_entry_c.data = swap_bytes(ioctl_data);

   // ioctl_addr[0] and any address bits above ADDR_W are intentionally dropped.
   assign unused_bits_c = ^{ioctl_addr, head_c.addr};

   loader_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .din   (push_entry_c),
      .pop   (pop_c),
      .dout  (head_c),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign count_next_c = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);

   // Write FSM next state plus all registered-output next values.
   always_comb begin
      state_d    = state_q;
      pop_c      = 1'b0;
      sdr_addr_d = sdr_addr_q;
      sdr_din_d  = sdr_din_q;
      active_d   = active_q;
      overflow_d = overflow_q;

      case (state_q)
         IDLE: if (!fifo_empty) state_d = REQ;
         REQ:  if (sdr_busy)    state_d = ACK;
         ACK: begin
            if (busy_fall_c) begin
               pop_c   = 1'b1;
               state_d = (fifo_count > CNT_W'(1)) ? REQ : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Request drops for one cycle on a pop so the new head is loaded before
      // the next request is shown.
      sdr_wr_d = (state_d != IDLE) & ~pop_c;
      if (sdr_wr_d) begin
         sdr_addr_d = head_c.addr[ADDR_W-1:0];
         sdr_din_d  = head_c.data;
      end

      // One slot of slack covers the strobe racing the wait assertion.
      wait_d = (count_next_c >= WAIT_LEVEL);

      done_d = active_q & ~ioctl_download & fifo_empty & (state_q == IDLE);

      if (done_d)        active_d = 1'b0;
      else if (accept_c) active_d = 1'b1;

      // Sticky status restarts with the first beat of a new download.
      if (accept_c & ~active_q) overflow_d = 1'b0;
      if (accept_c & fifo_full) overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         wait_q     <= 1'b0;
         sdr_wr_q   <= 1'b0;
         sdr_addr_q <= '0;
         sdr_din_q  <= '0;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= sdr_busy;
         wait_q     <= wait_d;
         sdr_wr_q   <= sdr_wr_d;
         sdr_addr_q <= sdr_addr_d;
         sdr_din_q  <= sdr_din_d;
         active_q   <= active_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [15:0] checksum_q, checksum_d;

   // Sum words as they leave the FIFO, i.e. as they are committed to SDRAM.
   always_comb begin
      checksum_d = checksum_q;
      if (accept_c & ~active_q) checksum_d = 16'h0000;
      else if (pop_c)           checksum_d = checksum_q + head_c.data;
   end

   always_ff @(posedge clk) begin
      if (rst) checksum_q <= 16'h0000;
      else     checksum_q <= checksum_d;
   end

   assign checksum = checksum_q;
`else
   assign checksum = 16'h0000;
`endif

   assign ioctl_wait = wait_q;
   assign sdr_wr     = sdr_wr_q;
   assign sdr_addr   = sdr_addr_q;
   assign sdr_din    = sdr_din_q;
   assign active     = active_q;
   assign done       = done_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench for ioctl_sdram_loader: table of single-beat downloads, then
// hand-written back-pressure, overflow, code-slot, checksum and reset sequences.
module tb_ioctl_sdram_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [15:0] ioctl_data;
   logic        ioctl_wait;
   logic [23:0] sdr_addr;
   logic [15:0] sdr_din;
   logic        sdr_wr;
   logic        sdr_busy = 1'b0;
   logic        active;
   logic        done;
   logic        overflow;
   logic [15:0] checksum;

   always #5 clk = ~clk;

   ioctl_sdram_loader #(
      .ADDR_W     (24),
      .FIFO_DEPTH (4),
      .BASE_ADDR  (24'h000000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_data     (ioctl_data),
      .ioctl_wait     (ioctl_wait),
      .sdr_addr       (sdr_addr),
      .sdr_din        (sdr_din),
      .sdr_wr         (sdr_wr),
      .sdr_busy       (sdr_busy),
      .active         (active),
      .done           (done),
      .overflow       (overflow),
      .checksum       (checksum)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: bound expired, got timeout expected event", name);
   endtask

   // SDRAM model: logs each new request and answers with a 3-cycle busy pulse,
   // or holds busy high while busy_force is set.
   logic [39:0] wlog [64];
   int          wlog_n   = 0;
   logic        prev_wr  = 1'b0;
   int          busy_cnt = 0;
   logic        busy_force = 1'b0;

   always @(negedge clk) begin
      prev_wr <= sdr_wr;
      if (sdr_wr && !prev_wr && wlog_n < 64) begin
         wlog[wlog_n] <= {sdr_addr, sdr_din};
         wlog_n       <= wlog_n + 1;
      end
      if (busy_force) begin
         sdr_busy <= 1'b1;
         busy_cnt <= 0;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
         sdr_busy <= (busy_cnt > 1);
      end else if (sdr_wr && !sdr_busy) begin
         sdr_busy <= 1'b1;
         busy_cnt <= 3;
      end else begin
         sdr_busy <= 1'b0;
      end
   end

   task automatic beat(input logic [7:0] idx, input logic [24:0] addr, input logic [15:0] data);
      @(negedge clk);
      ioctl_index = idx;
      ioctl_addr  = addr;
      ioctl_data  = data;
      ioctl_wr    = 1'b1;
      @(negedge clk);
      ioctl_wr    = 1'b0;
   endtask

   task automatic wait_writes(input int target, input int budget, input string name);
      int k = 0;
      while (wlog_n < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (wlog_n < target) fail_now(name);
   endtask

   task automatic finish_download(input string name, input int exp_done,
                                  output logic [15:0] chk);
      int d = 0;
      chk = 16'h0000;
      ioctl_download = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done) begin
            d++;
            chk = checksum;
         end
      end
      check({name, "_done_cnt"}, 40'(d), 40'(exp_done));
      check({name, "_active_end"}, 40'(active), 40'd0);
   endtask

   typedef struct {
      logic [7:0]  idx;
      logic [24:0] addr;
      logic [15:0] data;
      logic        exp_wr;
      logic [23:0] exp_addr;
      logic [15:0] exp_din;
   } vec_t;

   vec_t vecs [5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] chk;
      logic        aseen;
      int          base;
      int          k;
      string       nm;

      vecs[0] = '{8'h00, 25'h0000010, 16'h3412, 1'b1, 24'h000008, 16'h1234};
      vecs[1] = '{8'h01, 25'h1FFFFFE, 16'hABCD, 1'b1, 24'hFFFFFF, 16'hCDAB};
      vecs[2] = '{8'h02, 25'h0000021, 16'h00FF, 1'b1, 24'h000010, 16'hFF00};
      vecs[3] = '{8'hFF, 25'h0000100, 16'h5555, 1'b0, 24'h000000, 16'h0000};
      vecs[4] = '{8'h7F, 25'h0000000, 16'h8001, 1'b1, 24'h000000, 16'h0180};

      rst            = 1'b1;
      ioctl_download = 1'b0;
      ioctl_index    = 8'h00;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_data     = '0;
      repeat (3) @(negedge clk);
      check("rst_wait", 40'(ioctl_wait), 40'd0);
      check("rst_sdr_wr", 40'(sdr_wr), 40'd0);
      check("rst_sdr_addr", 40'(sdr_addr), 40'd0);
      check("rst_sdr_din", 40'(sdr_din), 40'd0);
      check("rst_active", 40'(active), 40'd0);
      check("rst_done", 40'(done), 40'd0);
      check("rst_overflow", 40'(overflow), 40'd0);
      check("rst_checksum", 40'(checksum), 40'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table: one beat per download; latency, mapping, swap, completion.
      for (int i = 0; i < 5; i++) begin
         nm   = $sformatf("vec%0d", i);
         base = wlog_n;
         ioctl_download = 1'b1;
         beat(vecs[i].idx, vecs[i].addr, vecs[i].data);
         check({nm, "_wr_n1"}, 40'(sdr_wr), 40'd0);
         @(negedge clk);
         check({nm, "_wr_n2"}, 40'(sdr_wr), 40'(vecs[i].exp_wr));
         aseen = active;
         repeat (10) begin
            @(negedge clk);
            aseen = aseen | active;
         end
         check({nm, "_nwrites"}, 40'(wlog_n - base), 40'(vecs[i].exp_wr));
         check({nm, "_active"}, 40'(aseen), 40'(vecs[i].exp_wr));
         if (vecs[i].exp_wr)
            check({nm, "_word"}, wlog[base], {vecs[i].exp_addr, vecs[i].exp_din});
         finish_download(nm, int'(vecs[i].exp_wr), chk);
`ifdef LOADER_CHECKSUM_EN
         if (vecs[i].exp_wr) check({nm, "_checksum"}, 40'(chk), 40'(vecs[i].exp_din));
`else
         if (vecs[i].exp_wr) check({nm, "_checksum"}, 40'(chk), 40'd0);
`endif
      end

      // Back-pressure: busy stuck for 20 cycles, 8 beats obeying ioctl_wait.
      base = wlog_n;
      busy_force = 1'b1;
      ioctl_download = 1'b1;
      fork
         begin
            repeat (20) @(negedge clk);
            busy_force = 1'b0;
         end
      join_none
      for (int i = 0; i < 8; i++) begin
         k = 0;
         while (ioctl_wait && k < 100) begin
            @(negedge clk);
            k++;
         end
         if (ioctl_wait) fail_now("bp_wait_release");
         beat(8'h00, 25'h0000200 + 25'(2 * i), {8'(i), 8'h5A});
         if (i == 1) check("bp_wait_occ2", 40'(ioctl_wait), 40'd0);
         if (i == 2) check("bp_wait_occ3", 40'(ioctl_wait), 40'd1);
      end
      wait_writes(base + 8, 200, "bp_writes");
      check("bp_overflow", 40'(overflow), 40'd0);
      for (int i = 0; i < 8; i++)
         check($sformatf("bp_word%0d", i), wlog[base + i], {24'h000100 + 24'(i), 8'h5A, 8'(i)});
      finish_download("bp", 1, chk);

      // Overflow: 5 beats into a full FIFO ignoring ioctl_wait.
      base = wlog_n;
      busy_force = 1'b1;
      ioctl_download = 1'b1;
      for (int i = 0; i < 5; i++) begin
         beat(8'h04, 25'h0000400 + 25'(2 * i), {8'(i), 8'hC3});
         if (i == 3) check("ovf_before", 40'(overflow), 40'd0);
         if (i == 4) check("ovf_after", 40'(overflow), 40'd1);
      end
      repeat (3) @(negedge clk);
      busy_force = 1'b0;
      wait_writes(base + 4, 100, "ovf_writes");
      repeat (10) @(negedge clk);
      check("ovf_nwrites", 40'(wlog_n - base), 40'd4);
      for (int i = 0; i < 4; i++)
         check($sformatf("ovf_word%0d", i), wlog[base + i], {24'h000200 + 24'(i), 8'hC3, 8'(i)});
      finish_download("ovf", 1, chk);
      check("ovf_sticky_after_done", 40'(overflow), 40'd1);

      // Code slot: never written, no activity, sticky status untouched.
      base = wlog_n;
      ioctl_download = 1'b1;
      aseen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         beat(8'hFF, 25'h0000800 + 25'(2 * i), 16'h1111);
         aseen = aseen | active;
      end
      repeat (8) begin
         @(negedge clk);
         aseen = aseen | active;
      end
      check("code_nwrites", 40'(wlog_n - base), 40'd0);
      check("code_active", 40'(aseen), 40'd0);
      check("code_overflow_kept", 40'(overflow), 40'd1);
      finish_download("code", 0, chk);

      // Checksum over three words; overflow clears on the first new beat.
      base = wlog_n;
      ioctl_download = 1'b1;
      beat(8'h03, 25'h0000000, 16'h0100);
      check("cks_overflow_clr", 40'(overflow), 40'd0);
      beat(8'h03, 25'h0000002, 16'hFFFF);
      beat(8'h03, 25'h0000004, 16'h1000);
      wait_writes(base + 3, 100, "cks_writes");
      repeat (8) @(negedge clk);
      check("cks_word2", wlog[base + 2], {24'h000002, 16'h0010});
      finish_download("cks", 1, chk);
`ifdef LOADER_CHECKSUM_EN
      check("cks_value", 40'(chk), 40'h0010);
`else
      check("cks_value", 40'(chk), 40'h0000);
`endif

      // Reset during ACK with three entries buffered.
      base = wlog_n;
      busy_force = 1'b1;
      ioctl_download = 1'b1;
      for (int i = 0; i < 3; i++) beat(8'h05, 25'h0000600 + 25'(2 * i), 16'hBEEF);
      repeat (2) @(negedge clk);
      check("mrst_wr_before", 40'(sdr_wr), 40'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_sdr_wr", 40'(sdr_wr), 40'd0);
      check("mrst_wait", 40'(ioctl_wait), 40'd0);
      check("mrst_sdr_addr", 40'(sdr_addr), 40'd0);
      check("mrst_sdr_din", 40'(sdr_din), 40'd0);
      check("mrst_active", 40'(active), 40'd0);
      check("mrst_done", 40'(done), 40'd0);
      check("mrst_overflow", 40'(overflow), 40'd0);
      check("mrst_checksum", 40'(checksum), 40'd0);
      rst = 1'b0;
      busy_force = 1'b0;
      repeat (15) @(negedge clk);
      check("mrst_nwrites", 40'(wlog_n - base), 40'd1);
      finish_download("mrst", 0, chk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
